// File: rtl/seq_divider_if.sv
// Handshake and data bundle between the execute-stage ALU and the
// iterative divider. The ALU side is the master, the divider the slave.
interface seq_divider_if;
  logic        start;
  logic [1:0]  div_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start,
    output div_op,
    output dividend,
    output divisor,
    output kill,
    input  busy,
    input  done,
    input  result
  );

  modport slave (
    input  start,
    input  div_op,
    input  dividend,
    input  divisor,
    input  kill,
    output busy,
    output done,
    output result
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One quotient bit per cycle, RISC-V divide-by-zero and signed-overflow
// results, registered busy/done/result, kill aborts without a done pulse.
module seq_divider (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Two's complement magnitude; 0x80000000 maps onto itself, which is
  // exactly 2^31 when read as unsigned, so the datapath stays correct.
  function automatic logic [31:0] abs32(input logic [31:0] value);
    logic [31:0] mag;
    mag = value[31] ? (~value + 32'd1) : value;
    return mag;
  endfunction

  // Conditional two's complement negation used by the sign fix-up.
  function automatic logic [31:0] cond_neg32(input logic        neg,
                                             input logic [31:0] value);
    logic [31:0] res;
    res = neg ? (~value + 32'd1) : value;
    return res;
  endfunction

  state_t      state_r;
  logic [1:0]  op_r;
  logic [31:0] dvs_r;
  logic [31:0] quo_r;
  logic [32:0] rem_r;
  logic [4:0]  count_r;
  logic        neg_quo_r;
  logic        neg_rem_r;
  logic        special_r;
  logic        busy_r;
  logic        done_r;
  logic [31:0] result_r;

  logic        signed_op_s;
  logic [31:0] abs_dvd_s;
  logic [31:0] abs_dvs_s;
  logic        div_zero_s;
  logic        overflow_s;
  logic        neg_quo_s;
  logic        neg_rem_s;
  logic [32:0] partial_s;
  logic [32:0] trial_s;
  logic [31:0] fix_q_s;
  logic [31:0] fix_r_s;
  logic [31:0] fix_result_s;

  // Decode the incoming request: signedness, magnitudes and special cases.
  always_comb begin
    signed_op_s = 1'b0;
    abs_dvd_s   = bus.dividend;
    abs_dvs_s   = bus.divisor;
    neg_quo_s   = 1'b0;
    neg_rem_s   = 1'b0;
    overflow_s  = 1'b0;
    // div_op[0]==0 selects the signed flavours (DIV, REM)
    signed_op_s = ~bus.div_op[0];
    div_zero_s  = (bus.divisor == 32'd0);
    if (signed_op_s) begin
      abs_dvd_s  = abs32(bus.dividend);
      abs_dvs_s  = abs32(bus.divisor);
      neg_quo_s  = bus.dividend[31] ^ bus.divisor[31];
      neg_rem_s  = bus.dividend[31];
      overflow_s = (bus.dividend == 32'h8000_0000) &&
                   (bus.divisor  == 32'hFFFF_FFFF);
    end else begin
      abs_dvd_s  = bus.dividend;
      abs_dvs_s  = bus.divisor;
      neg_quo_s  = 1'b0;
      neg_rem_s  = 1'b0;
      overflow_s = 1'b0;
    end
  end

  // One restoring step: shift in the next dividend bit and trial-subtract.
  always_comb begin
    partial_s = {rem_r[31:0], quo_r[31]};
    trial_s   = partial_s - {1'b0, dvs_r};
  end

  // Final result selection; special-case results skip sign correction.
  always_comb begin
    fix_q_s      = quo_r;
    fix_r_s      = rem_r[31:0];
    fix_result_s = 32'd0;
    if (special_r) begin
      fix_q_s = quo_r;
      fix_r_s = rem_r[31:0];
    end else begin
      fix_q_s = cond_neg32(neg_quo_r, quo_r);
      fix_r_s = cond_neg32(neg_rem_r, rem_r[31:0]);
    end
    if (op_r[1]) begin
      fix_result_s = fix_r_s;
    end else begin
      fix_result_s = fix_q_s;
    end
  end

  // Control FSM and datapath registers; reset and kill take precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'd0;
      dvs_r     <= 32'd0;
      quo_r     <= 32'd0;
      rem_r     <= 33'd0;
      count_r   <= 5'd0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      special_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.kill) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (bus.start) begin
            op_r      <= bus.div_op;
            dvs_r     <= abs_dvs_s;
            neg_quo_r <= neg_quo_s;
            neg_rem_r <= neg_rem_s;
            count_r   <= 5'd0;
            busy_r    <= 1'b1;
            if (div_zero_s) begin
              // Remainder is the raw dividend, not its magnitude
              quo_r     <= 32'hFFFF_FFFF;
              rem_r     <= {1'b0, bus.dividend};
              special_r <= 1'b1;
              state_r   <= ST_FIX;
            end else if (overflow_s) begin
              quo_r     <= 32'h8000_0000;
              rem_r     <= 33'd0;
              special_r <= 1'b1;
              state_r   <= ST_FIX;
            end else begin
              quo_r     <= abs_dvd_s;
              rem_r     <= 33'd0;
              special_r <= 1'b0;
              state_r   <= ST_CALC;
            end
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end

        ST_CALC: begin
          if (bus.kill) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            if (trial_s[32] == 1'b0) begin
              rem_r <= trial_s;
              quo_r <= {quo_r[30:0], 1'b1};
            end else begin
              rem_r <= partial_s;
              quo_r <= {quo_r[30:0], 1'b0};
            end
            count_r <= count_r + 5'd1;
            if (count_r == 5'd31) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_CALC;
            end
          end
        end

        ST_FIX: begin
          if (bus.kill) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            result_r <= fix_result_s;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_DONE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

  seq_divider_checker u_checker (
    .clk  (clk),
    .rst  (rst),
    .busy (busy_r),
    .done (done_r)
  );

endmodule

// Handshake invariants: busy and done are exclusive, done is a single pulse.
module seq_divider_checker (
  input logic clk,
  input logic rst,
  input logic busy,
  input logic done
);
  logic done_q_r;

  // Remember the previous done level for the pulse-width check.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q_r <= 1'b0;
    end else begin
      done_q_r <= done;
    end
  end

  // Evaluate the invariants on every active edge outside reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(busy && done));
      assert (!(done_q_r && done));
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider.
module tb_seq_divider;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  seq_divider_if bus_if();

  seq_divider dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns just after the start edge E0.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus_if.start    = 1'b1;
    bus_if.div_op   = op;
    bus_if.dividend = a;
    bus_if.divisor  = b;
    step();
    bus_if.start    = 1'b0;
  endtask

  // Count edges after E0 until done is seen; -1 when the budget runs out.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus_if.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    issue(op, a, b);
    wait_done(lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
    end
    checks++;
    if (bus_if.done !== 1'b0) begin
      failures++; $display("FAIL reset_done: got %b expected 0", bus_if.done);
    end
    checks++;
    if (bus_if.result !== 32'h0000_0000) begin
      failures++; $display("FAIL reset_result: got %h expected 00000000", bus_if.result);
    end
  endtask

  task automatic test_unsigned();
    int lat;
    issue(OP_DIVU, 32'd100, 32'd7);
    checks++;
    if (bus_if.busy !== 1'b1) begin
      failures++; $display("FAIL divu_busy: got %b expected 1", bus_if.busy);
    end
    wait_done(lat);
    checks++;
    if (lat !== 33) begin
      failures++; $display("FAIL divu_latency: got %0d expected 33", lat);
    end
    checks++;
    if (bus_if.result !== 32'd14) begin
      failures++; $display("FAIL divu_result: got %h expected 0000000e", bus_if.result);
    end
    step();
    run_op(OP_REMU, 32'd100, 32'd7, lat);
    checks++;
    if (lat !== 33 || bus_if.result !== 32'd2) begin
      failures++; $display("FAIL remu_result: got %h lat %0d expected 00000002 lat 33", bus_if.result, lat);
    end
    step();
  endtask

  task automatic test_signed();
    int lat;
    logic [1:0]  ops [4] = '{OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0001};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], lat);
      checks++;
      if (lat !== 33 || bus_if.result !== exp[i]) begin
        failures++;
        $display("FAIL signed_%0d: got %h lat %0d expected %h lat 33", i, bus_if.result, lat, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_div_by_zero();
    int lat;
    logic [1:0]  ops [4] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], 32'd0, lat);
      checks++;
      if (lat !== 1 || bus_if.result !== exp[i]) begin
        failures++;
        $display("FAIL divzero_%0d: got %h lat %0d expected %h lat 1", i, bus_if.result, lat, exp[i]);
      end
      step();
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat !== 1 || bus_if.result !== 32'h8000_0000) begin
      failures++; $display("FAIL ovf_div: got %h lat %0d expected 80000000 lat 1", bus_if.result, lat);
    end
    step();
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat !== 1 || bus_if.result !== 32'h0000_0000) begin
      failures++; $display("FAIL ovf_rem: got %h lat %0d expected 00000000 lat 1", bus_if.result, lat);
    end
    step();
  endtask

  task automatic test_start_while_busy();
    int lat;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (4) step();
    issue(OP_DIVU, 32'd1000, 32'd3);
    wait_done(lat);
    // lat counts from the ignored start, which sits 5 edges after E0
    checks++;
    if (lat !== 28 || bus_if.result !== 32'd14) begin
      failures++; $display("FAIL busy_ignore: got %h lat %0d expected 0000000e lat 28", bus_if.result, lat);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(OP_DIVU, 32'd100, 32'd7, lat);
    // Start again while done is high
    issue(OP_DIVU, 32'd50, 32'd5);
    checks++;
    if (bus_if.busy !== 1'b1 || bus_if.result !== 32'd14) begin
      failures++; $display("FAIL b2b_accept: got busy %b result %h expected busy 1 result 0000000e", bus_if.busy, bus_if.result);
    end
    wait_done(lat);
    checks++;
    if (lat + 1 !== 34 || bus_if.result !== 32'd10) begin
      failures++; $display("FAIL b2b_second: got %h spacing %0d expected 0000000a spacing 34", bus_if.result, lat + 1);
    end
    step();
  endtask

  task automatic test_kill();
    logic seen;
    issue(OP_DIVU, 32'd1000, 32'd10);
    repeat (9) step();
    bus_if.kill = 1'b1;
    step();
    bus_if.kill = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.result !== 32'd10) begin
      failures++; $display("FAIL kill_calc: got busy %b done %b result %h expected 0 0 0000000a", bus_if.busy, bus_if.done, bus_if.result);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL kill_no_done: got %b expected 0", seen);
    end
    // kill together with start in IDLE drops the start
    bus_if.kill = 1'b1;
    issue(OP_DIVU, 32'd5, 32'd0);
    bus_if.kill = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b0) begin
      failures++; $display("FAIL kill_start: got busy %b expected 0", bus_if.busy);
    end
    step();
    checks++;
    if (bus_if.done !== 1'b0 || bus_if.result !== 32'd10) begin
      failures++; $display("FAIL kill_start_done: got done %b result %h expected 0 0000000a", bus_if.done, bus_if.result);
    end
  endtask

  task automatic test_rst_abort();
    logic seen;
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || bus_if.result !== 32'd0) begin
      failures++; $display("FAIL rst_abort: got busy %b done %b result %h expected 0 0 00000000", bus_if.busy, bus_if.done, bus_if.result);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus_if.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL rst_no_done: got %b expected 0", seen);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rst             = 1'b1;
    bus_if.start    = 1'b0;
    bus_if.kill     = 1'b0;
    bus_if.div_op   = 2'b00;
    bus_if.dividend = 32'd0;
    bus_if.divisor  = 32'd0;
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_start_while_busy();
    test_back_to_back();
    test_kill();
    test_rst_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
